// File: rtl/tdt_dmi_cdc_arb_if.sv
// tdt_dmi_cdc_arb_if: requester channels and DMI target bundle.
// Master drives requests and target replies; slave is the arbiter.
interface tdt_dmi_cdc_arb_if #(
  parameter int REQ_W = 41,
  parameter int RSP_W = 34
);
  logic             ch0_req;
  logic [REQ_W-1:0] ch0_req_data;
  logic             ch0_ack;
  logic [RSP_W-1:0] ch0_rsp_data;
  logic             ch1_req;
  logic [REQ_W-1:0] ch1_req_data;
  logic             ch1_ack;
  logic [RSP_W-1:0] ch1_rsp_data;
  logic             dmi_req_vld;
  logic [REQ_W-1:0] dmi_req_data;
  logic             dmi_req_rdy;
  logic             dmi_rsp_vld;
  logic [RSP_W-1:0] dmi_rsp_data;
  logic             busy;
  logic             grant_id;

  modport master (
    output ch0_req, ch0_req_data,
    output ch1_req, ch1_req_data,
    output dmi_req_rdy, dmi_rsp_vld, dmi_rsp_data,
    input  ch0_ack, ch0_rsp_data,
    input  ch1_ack, ch1_rsp_data,
    input  dmi_req_vld, dmi_req_data,
    input  busy, grant_id
  );

  modport slave (
    input  ch0_req, ch0_req_data,
    input  ch1_req, ch1_req_data,
    input  dmi_req_rdy, dmi_rsp_vld, dmi_rsp_data,
    output ch0_ack, ch0_rsp_data,
    output ch1_ack, ch1_rsp_data,
    output dmi_req_vld, dmi_req_data,
    output busy, grant_id
  );
endinterface

// File: rtl/tdt_dmi_cdc_arb.sv
// tdt_dmi_cdc_arb: two async four-phase requesters sharing one
// DMI target, round-robin arbitrated in the dst_clk domain.
module tdt_dmi_cdc_arb #(
  parameter int SYNC_NUM = 3,
  parameter int REQ_W    = 41,
  parameter int RSP_W    = 34
) (
  input logic              dst_clk,
  input logic              dst_rst_b,
  tdt_dmi_cdc_arb_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RSP,
    ACK
  } state_e;

  state_e state_q, state_d;

  logic [SYNC_NUM-1:0] sync0_q, sync0_d;
  logic [SYNC_NUM-1:0] sync1_q, sync1_d;
  logic                sreq0, sreq1;

  logic             ptr_q, ptr_d;
  logic             gnt_q, gnt_d;
  logic             vld_q, vld_d;
  logic [REQ_W-1:0] req_q, req_d;
  logic             ack0_q, ack0_d;
  logic             ack1_q, ack1_d;
  logic [RSP_W-1:0] rsp0_q, rsp0_d;
  logic [RSP_W-1:0] rsp1_q, rsp1_d;
  logic             win;
  logic             gnt_sreq;

  assign sync0_d = {sync0_q[SYNC_NUM-2:0], bus.ch0_req};
  assign sync1_d = {sync1_q[SYNC_NUM-2:0], bus.ch1_req};
  assign sreq0   = sync0_q[SYNC_NUM-1];
  assign sreq1   = sync1_q[SYNC_NUM-1];

  // Round-robin pick and one-transaction-at-a-time sequencing.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    vld_d    = vld_q;
    req_d    = req_q;
    ack0_d   = ack0_q;
    ack1_d   = ack1_q;
    rsp0_d   = rsp0_q;
    rsp1_d   = rsp1_q;
    win      = (sreq0 & sreq1) ? ptr_q : sreq1;
    gnt_sreq = gnt_q ? sreq1 : sreq0;
    unique case (state_q)
      IDLE: begin
        if (sreq0 | sreq1) begin
          gnt_d   = win;
          req_d   = win ? bus.ch1_req_data
                        : bus.ch0_req_data;
          vld_d   = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.dmi_req_rdy) begin
          vld_d   = 1'b0;
          state_d = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (bus.dmi_rsp_vld) begin
          if (gnt_q) begin
            ack1_d = 1'b1;
            rsp1_d = bus.dmi_rsp_data;
          end else begin
            ack0_d = 1'b1;
            rsp0_d = bus.dmi_rsp_data;
          end
          state_d = ACK;
        end
      end
      ACK: begin
        if (!gnt_sreq) begin
          ack0_d  = 1'b0;
          ack1_d  = 1'b0;
          ptr_d   = ~gnt_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Request-level synchronisers, cleared by reset.
  always_ff @(posedge dst_clk or negedge dst_rst_b) begin
    if (!dst_rst_b) begin
      sync0_q <= '0;
      sync1_q <= '0;
    end else begin
      sync0_q <= sync0_d;
      sync1_q <= sync1_d;
    end
  end

  // Controller state and every registered output.
  always_ff @(posedge dst_clk or negedge dst_rst_b) begin
    if (!dst_rst_b) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      gnt_q   <= 1'b0;
      vld_q   <= 1'b0;
      req_q   <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      rsp0_q  <= '0;
      rsp1_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      vld_q   <= vld_d;
      req_q   <= req_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      rsp0_q  <= rsp0_d;
      rsp1_q  <= rsp1_d;
    end
  end

  assign bus.dmi_req_vld  = vld_q;
  assign bus.dmi_req_data = req_q;
  assign bus.ch0_ack      = ack0_q;
  assign bus.ch1_ack      = ack1_q;
  assign bus.ch0_rsp_data = rsp0_q;
  assign bus.ch1_rsp_data = rsp1_q;
  assign bus.grant_id     = gnt_q;
  assign bus.busy         = (state_q != IDLE);

endmodule

// File: doc/tdt_dmi_cdc_arb.md
# tdt_dmi_cdc_arb

Destination-domain controller that shares one DMI target port between two asynchronous requesters, e.g. the JTAG DTM and the system APB debug path. It synchronises each requester's four-phase request level through SYNC_NUM-stage synchroniser chains and arbitrates round-robin between the two channels. It sequences one transaction at a time on the DMI target handshake, then returns a level acknowledge plus held response data to the winning channel.

## Interface
- SYNC_NUM, 3, synchroniser depth per request input; legal values are 2 or more.
- REQ_W, 41, request payload width: addr[40:34], wdata[33:2], op[1:0].
- RSP_W, 34, response payload width: rdata[33:2], status[1:0].
- dst_clk  in  1  destination clock; the entire block runs on it.
- dst_rst_b  in  1  reset, asynchronous, active-low; clock dst_clk.
- ch0_req / ch1_req  in  1  four-phase request level from the source domain (asynchronous).
- ch0_req_data / ch1_req_data  in  REQ_W  request payload; the source holds it stable from req rise until ack rise.
- ch0_ack / ch1_ack  out  1  four-phase acknowledge level, driven directly from a flop.
- ch0_rsp_data / ch1_rsp_data  out  RSP_W  response payload; valid and stable while the matching ack=1.
- dmi_req_vld  out  1  request valid toward the DMI target.
- dmi_req_data  out  REQ_W  captured payload of the granted channel.
- dmi_req_rdy  in  1  target accepts the request.
- dmi_rsp_vld  in  1  target response valid, single-cycle pulse.
- dmi_rsp_data  in  RSP_W  target response payload.
- busy  out  1  state is not IDLE.
- grant_id  out  1  channel currently or last granted.

## Operation
- Each chN_req passes through a SYNC_NUM-stage shift synchroniser that resets to 0. The output is sreqN. No raw chN_req reaches any logic other than the synchroniser.
- The FSM has four states: IDLE, ISSUE, WAIT_RSP, ACK.
  - IDLE: if any sreqN=1, pick the winner, capture its chN_req_data into dmi_req_data, set grant_id, and go to ISSUE.
  - ISSUE: dmi_req_vld=1. When dmi_req_rdy=1, go to WAIT_RSP.
  - WAIT_RSP: when dmi_rsp_vld=1, latch dmi_rsp_data into the granted channel's rsp register, set that channel's ack to 1, and go to ACK.
  - ACK: hold ack. When sreq of the granted channel is 0, clear ack, flip the round-robin pointer away from grant_id, and go to IDLE.
- Arbitration:
  - If only one sreq=1, that channel wins.
  - If both sreq=1, the channel named by the pointer wins.
  - The pointer resets to ch0.
- dmi_rsp_vld is ignored in IDLE, ISSUE and ACK. The target must not respond before it accepts the request.
- The non-granted channel's request stays pending; its ack and rsp_data do not change.
- chN_rsp_data keeps its last value after ack falls. It is only overwritten on the next response to that channel.
- Reset values:
  - State IDLE, pointer 0, grant_id 0.
  - dmi_req_vld 0, dmi_req_data 0.
  - ch0_ack 0, ch1_ack 0, ch0_rsp_data 0, ch1_rsp_data 0.
  - busy 0.
  - All synchroniser stages 0.
- An asserted reset at any point, including mid-transaction, returns the block to the reset values. No pending request survives reset. The source side must restart its handshake.

## Timing
- A chN_req rise appears on sreqN after SYNC_NUM dst_clk edges.
- Grant: the IDLE→ISSUE edge is the first edge with sreqN=1. dmi_req_vld is high in the following cycle.
- The DMI handshake completes on the edge where dmi_req_vld and dmi_req_rdy are both 1.
- ack rises on the edge that samples dmi_rsp_vld=1 in WAIT_RSP. rsp_data is valid on the same edge.
- A chN_req fall reaches sreqN after SYNC_NUM edges. ack falls on the next edge and the state is IDLE the same cycle.
- A new grant is possible on the edge after the return to IDLE.
- Minimum dst-side occupancy is SYNC_NUM + 4 cycles per transaction, excluding the source-side ack synchronisation.
- Simultaneous sreq rises are resolved by the pointer with no lost request.

## Test plan
- Single ch0 read, SYNC_NUM=3: ch0_req=1 with data 0x0A_DEADBEEF_1, rdy tied 1, rsp 0x12345678_0 one cycle after accept. Expected: dmi_req_vld high 4 cycles after the req rise, ch0_ack=1, ch0_rsp_data=0x12345678_0, and ch0_ack=0 4 cycles after the req falls.
- Both channels request on the same edge after reset. Expected: ch0 served first, grant_id=0; ch1 served next, grant_id=1. Repeat both together: ch0 is served first again, because the pointer flipped back to ch0 after serving ch1.
- dmi_req_rdy held 0 for 10 cycles. Expected: dmi_req_vld stays 1 with dmi_req_data constant, and no ack is asserted.
- Spurious dmi_rsp_vld in IDLE and in ISSUE. Expected: ignored; rsp registers and acks are unchanged.
- dst_rst_b asserted during WAIT_RSP with ch1 granted. Expected: all outputs return to reset values immediately; after reset release and with ch1_req still high, a new grant occurs after SYNC_NUM edges.
- ch0 holds req high after ack with ch1 pending. Expected: no grant to ch1 until ch0's ack falls; ch1 is granted on the following edge.
